// File: rtl/fnd_pkg.sv
// ============================================================================
// Module  : fnd_pkg
// Brief   : Shared code points and types for the FND display path.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

package fnd_pkg;

    typedef logic [3:0] fnd_code_t;

    localparam fnd_code_t FND_CODE_BLANK = 4'hF;
    localparam fnd_code_t FND_CODE_DP    = 4'hA;

endpackage : fnd_pkg

`default_nettype wire

// File: rtl/fnd_scan_prescaler.sv
// ============================================================================
// Module  : fnd_scan_prescaler
// Brief   : Free-running 0..SCAN_DIV-1 divider with enable clear and tick.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module fnd_scan_prescaler #(
    parameter int SCAN_DIV = 100000
) (
    input  logic i_clk,
    input  logic i_reset_n,
    input  logic i_en,
    output logic o_tick
);

    localparam int CNT_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SCAN_DIV - 1);

    logic [CNT_W-1:0] count;

    always_ff @(posedge i_clk) begin
        if (!i_reset_n || !i_en) begin
            count <= '0;
        end else if (count == CNT_LAST) begin
            count <= '0;
        end else begin
            count <= count + 1'b1;
        end
    end

    assign o_tick = (count == CNT_LAST);

endmodule : fnd_scan_prescaler

`default_nettype wire

// File: rtl/fnd_scan_driver.sv
// ============================================================================
// Module  : fnd_scan_driver
// Brief   : Common-anode FND scan driver with per-frame digit shadowing.
//           Optional leading-zero blanking when FND_LZB_EN is defined.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module fnd_scan_driver
    import fnd_pkg::*;
#(
    parameter int DIGITS   = 4,
    parameter int SCAN_DIV = 100000
) (
    input  logic                  i_clk,
    input  logic                  i_reset_n,
    input  logic                  i_en,
    input  logic [4*DIGITS-1:0]   i_bcd,
    output logic [DIGITS-1:0]     o_fnd_com,
    output fnd_code_t             o_bcd_value,
    output logic                  o_frame_done
);

    localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DIGITS - 1);

    logic                tick;
    logic [IDX_W-1:0]    index;
    logic [4*DIGITS-1:0] shadow;
    fnd_code_t           digit_arr [DIGITS];
    fnd_code_t           code_sel;

    fnd_scan_prescaler #(
        .SCAN_DIV (SCAN_DIV)
    ) u_prescaler (
        .i_clk     (i_clk),
        .i_reset_n (i_reset_n),
        .i_en      (i_en),
        .o_tick    (tick)
    );

    generate
        for (genvar k = 0; k < DIGITS; k++) begin : g_digit
            assign digit_arr[k] = shadow[4*k +: 4];
        end
    endgenerate

`ifdef FND_LZB_EN
    // zero_above[k]: shadow digits k..DIGITS-1 are all zero
    logic [DIGITS-1:0] zero_above;

    always_comb begin
        zero_above             = '0;
        zero_above[DIGITS-1]   = (digit_arr[DIGITS-1] == 4'h0);
        for (int k = DIGITS - 2; k >= 0; k--) begin
            zero_above[k] = zero_above[k+1] && (digit_arr[k] == 4'h0);
        end
    end

    always_comb begin
        code_sel = digit_arr[index];
        if ((index != '0) && zero_above[index]) begin
            code_sel = FND_CODE_BLANK;
        end
    end
`else
    always_comb begin
        code_sel = digit_arr[index];
    end
`endif

    // Outputs follow the index register one edge later, so commons and code
    // always move together and the shadow swap lands exactly on digit 0.
    always_ff @(posedge i_clk) begin
        if (!i_reset_n) begin
            index        <= '0;
            shadow       <= '0;
            o_fnd_com    <= '1;
            o_bcd_value  <= FND_CODE_BLANK;
            o_frame_done <= 1'b0;
        end else if (!i_en) begin
            index        <= '0;
            shadow       <= i_bcd;
            o_fnd_com    <= '1;
            o_bcd_value  <= FND_CODE_BLANK;
            o_frame_done <= 1'b0;
        end else begin
            o_fnd_com    <= ~(DIGITS'(1) << index);
            o_bcd_value  <= code_sel;
            o_frame_done <= 1'b0;
            if (tick) begin
                if (index == IDX_LAST) begin
                    index        <= '0;
                    shadow       <= i_bcd;
                    o_frame_done <= 1'b1;
                end else begin
                    index <= index + 1'b1;
                end
            end
        end
    end

endmodule : fnd_scan_driver

`default_nettype wire

// File: tb/tb_fnd_scan_driver.sv
// ============================================================================
// Module  : tb_fnd_scan_driver
// Brief   : Randomized self-checking bench for fnd_scan_driver against a
//           cycle-count reference model. Honours FND_LZB_EN when defined.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_fnd_scan_driver;

    localparam int DIGITS   = 4;
    localparam int SCAN_DIV = 4;
    localparam int FRAME    = DIGITS * SCAN_DIV;

    logic                clk = 1'b0;
    logic                reset_n;
    logic                en;
    logic [4*DIGITS-1:0] bcd;
    logic [DIGITS-1:0]   fnd_com;
    logic [3:0]          bcd_value;
    logic                frame_done;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference state: enabled edges since last reset/disable, and frame image
    int                  run;
    logic [4*DIGITS-1:0] m_shadow;
    logic [DIGITS-1:0]   exp_com;
    logic [3:0]          exp_val;
    logic                exp_done;

    fnd_scan_driver #(
        .DIGITS   (DIGITS),
        .SCAN_DIV (SCAN_DIV)
    ) dut (
        .i_clk        (clk),
        .i_reset_n    (reset_n),
        .i_en         (en),
        .i_bcd        (bcd),
        .o_fnd_com    (fnd_com),
        .o_bcd_value  (bcd_value),
        .o_frame_done (frame_done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (run=%0d t=%0t)", tag, got, exp, run, $time);
        end
    endtask

    function automatic logic [3:0] model_code(input int pos, input logic [4*DIGITS-1:0] img);
        logic [3:0] c;
        c = img[pos*4 +: 4];
`ifdef FND_LZB_EN
        if (pos > 0) begin
            bit all_zero;
            all_zero = 1'b1;
            for (int j = pos; j < DIGITS; j++)
                if (img[j*4 +: 4] != 4'h0) all_zero = 1'b0;
            if (all_zero) c = 4'hF;
        end
`endif
        return c;
    endfunction

    task automatic step(input logic r, input logic e, input logic [4*DIGITS-1:0] b);
        int pos;
        @(negedge clk);
        reset_n = r;
        en      = e;
        bcd     = b;
        @(posedge clk);
        if (!r) begin
            run = 0; m_shadow = '0;
            exp_com = '1; exp_val = 4'hF; exp_done = 1'b0;
        end else if (!e) begin
            run = 0; m_shadow = b;
            exp_com = '1; exp_val = 4'hF; exp_done = 1'b0;
        end else begin
            run++;
            pos      = ((run - 1) / SCAN_DIV) % DIGITS;
            exp_com  = ~(DIGITS'(1) << pos);
            exp_val  = model_code(pos, m_shadow);
            exp_done = (run % FRAME) == 0;
            if (exp_done) m_shadow = b;
        end
        #1;
        chk("fnd_com", 16'(fnd_com), 16'(exp_com));
        chk("bcd_value", 16'(bcd_value), 16'(exp_val));
        chk("frame_done", 16'(frame_done), 16'(exp_done));
    endtask

    function automatic logic [15:0] rand_bcd();
        logic [15:0] v;
        v = 16'($urandom);
        // Bias towards leading zeros so blanking is exercised
        for (int j = 3; j >= 1; j--)
            if ($urandom_range(0, 2) == 0) v[j*4 +: 4] = 4'h0;
            else break;
        return v;
    endfunction

    initial begin
        logic [15:0] cur;
        run = 0; m_shadow = '0;
        reset_n = 1'b0; en = 1'b1; bcd = 16'h1234;

        // Reset held with enable high: display stays dark
        for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 16'h1234);

        // Scan 1234, then swap to 5678 while digit 2 is lit in the third frame
        for (int i = 0; i < 40; i++) step(1'b1, 1'b1, 16'h1234);
        for (int i = 0; i < 40; i++) step(1'b1, 1'b1, 16'h5678);

        // Enable drop mid-frame during digit 1
        while (((run - 1) / SCAN_DIV) % DIGITS != 1) step(1'b1, 1'b1, 16'h5678);
        for (int i = 0; i < 5; i++) step(1'b1, 1'b0, 16'h5678);
        for (int i = 0; i < 20; i++) step(1'b1, 1'b1, 16'h5678);

        // Blanking / pass-through patterns, each loaded through a disable cycle
        step(1'b1, 1'b0, 16'h0050);
        for (int i = 0; i < FRAME + 2; i++) step(1'b1, 1'b1, 16'h0050);
        step(1'b1, 1'b0, 16'h0000);
        for (int i = 0; i < FRAME + 2; i++) step(1'b1, 1'b1, 16'h0000);
        step(1'b1, 1'b0, 16'h9A0B);
        for (int i = 0; i < FRAME + 2; i++) step(1'b1, 1'b1, 16'h9A0B);

        // Randomized traffic with occasional resets and enable drops
        cur = rand_bcd();
        for (int i = 0; i < 3000; i++) begin
            logic r, e;
            if ($urandom_range(0, 9) == 0) cur = rand_bcd();
            r = ($urandom_range(0, 299) != 0);
            e = ($urandom_range(0, 59) != 0);
            step(r, e, cur);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL timeout: simulation exceeded time budget");
        $fatal(1, "timeout");
    end

endmodule : tb_fnd_scan_driver

`default_nettype wire
